// File: rtl/tcp_rx_pipe_ctrl_pkg.sv
// tcp_rx_pipe_ctrl_pkg: shared types and constants for the TCP RX control FSM
package tcp_rx_pipe_ctrl_pkg;
  localparam int FLOWID_W = 10;
  localparam int TCP_SYN = 1;
  typedef enum logic [2:0] {
    IDLE, FAST_RD, FAST_SAVE, FAST_CALC, FAST_WR, NEW_WR, DROP
  } tcp_rx_ctrl_state_e;
  function automatic logic is_syn(input logic [7:0] flags);
    return flags[TCP_SYN];
  endfunction
endpackage

// File: rtl/tcp_rx_pipe_ctrl_if.sv
// tcp_rx_pipe_ctrl_if: handshake bundle between the RX control FSM and its datapath/peers
interface tcp_rx_pipe_ctrl_if;
  logic       src_tcp_rx_hdr_val;
  logic       tcp_rx_src_hdr_rdy;
  logic [7:0] src_tcp_rx_flags;
  logic       ctrl_datap_save_input;
  logic       ctrl_datap_save_flow_state;
  logic       ctrl_datap_save_calcs;
  logic       read_flow_cam_val;
  logic       read_flow_cam_hit;
  logic       store_flowid_cam;
  logic       store_flowid_manager;
  logic       flowid_manager_avail;
  logic       flowid_manager_req;
  logic       curr_rx_state_rd_req_val;
  logic       curr_rx_state_rd_req_rdy;
  logic       curr_tx_state_rd_req_val;
  logic       curr_tx_state_rd_req_rdy;
  logic       rx_head_ptr_rd_req_val;
  logic       rx_head_ptr_rd_req_rdy;
  logic       rx_tail_ptr_rd_req_val;
  logic       rx_tail_ptr_rd_req_rdy;
  logic       next_rx_state_wr_req_val;
  logic       next_rx_state_wr_req_rdy;
  logic       rx_tail_ptr_wr_req_val;
  logic       rx_tail_ptr_wr_req_rdy;
  logic       tx_head_ptr_wr_req_val;
  logic       tx_head_ptr_wr_req_rdy;
  logic       rx_sched_update_val;
  logic       rx_sched_update_rdy;
  logic       tcp_rx_dst_hdr_val;
  logic       tcp_rx_dst_hdr_rdy;
  logic       tcp_rx_dst_drop;
  logic       new_flow_val;
  logic       new_flow_rdy;
  logic       app_new_flow_notif_val;
  logic       app_new_flow_notif_rdy;
  logic       slow_path_send_pkt_enqueue_val;
  logic       slow_path_send_pkt_enqueue_rdy;
  modport master (
    input  src_tcp_rx_hdr_val, src_tcp_rx_flags, read_flow_cam_hit, flowid_manager_avail,
           curr_rx_state_rd_req_rdy, curr_tx_state_rd_req_rdy, rx_head_ptr_rd_req_rdy,
           rx_tail_ptr_rd_req_rdy, next_rx_state_wr_req_rdy, rx_tail_ptr_wr_req_rdy,
           tx_head_ptr_wr_req_rdy, rx_sched_update_rdy, tcp_rx_dst_hdr_rdy, new_flow_rdy,
           app_new_flow_notif_rdy, slow_path_send_pkt_enqueue_rdy,
    output tcp_rx_src_hdr_rdy, ctrl_datap_save_input, ctrl_datap_save_flow_state,
           ctrl_datap_save_calcs, read_flow_cam_val, store_flowid_cam, store_flowid_manager,
           flowid_manager_req, curr_rx_state_rd_req_val, curr_tx_state_rd_req_val,
           rx_head_ptr_rd_req_val, rx_tail_ptr_rd_req_val, next_rx_state_wr_req_val,
           rx_tail_ptr_wr_req_val, tx_head_ptr_wr_req_val, rx_sched_update_val,
           tcp_rx_dst_hdr_val, tcp_rx_dst_drop, new_flow_val, app_new_flow_notif_val,
           slow_path_send_pkt_enqueue_val
  );
  modport slave (
    output src_tcp_rx_hdr_val, src_tcp_rx_flags, read_flow_cam_hit, flowid_manager_avail,
           curr_rx_state_rd_req_rdy, curr_tx_state_rd_req_rdy, rx_head_ptr_rd_req_rdy,
           rx_tail_ptr_rd_req_rdy, next_rx_state_wr_req_rdy, rx_tail_ptr_wr_req_rdy,
           tx_head_ptr_wr_req_rdy, rx_sched_update_rdy, tcp_rx_dst_hdr_rdy, new_flow_rdy,
           app_new_flow_notif_rdy, slow_path_send_pkt_enqueue_rdy,
    input  tcp_rx_src_hdr_rdy, ctrl_datap_save_input, ctrl_datap_save_flow_state,
           ctrl_datap_save_calcs, read_flow_cam_val, store_flowid_cam, store_flowid_manager,
           flowid_manager_req, curr_rx_state_rd_req_val, curr_tx_state_rd_req_val,
           rx_head_ptr_rd_req_val, rx_tail_ptr_rd_req_val, next_rx_state_wr_req_val,
           rx_tail_ptr_wr_req_val, tx_head_ptr_wr_req_val, rx_sched_update_val,
           tcp_rx_dst_hdr_val, tcp_rx_dst_drop, new_flow_val, app_new_flow_notif_val,
           slow_path_send_pkt_enqueue_val
  );
endinterface

// File: rtl/tcp_rx_pipe_ctrl_hs_tracker.sv
// tcp_rx_ctrl_hs_tracker: per-channel done bits so each val drops right after its own handshake
module tcp_rx_ctrl_hs_tracker #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [N-1:0] val_i,
  input  logic [N-1:0] rdy_i,
  output logic [N-1:0] val_o,
  output logic         all_done_o
);
  logic [N-1:0] done_q, done_d, fire;
  assign val_o      = val_i & ~done_q;
  assign fire       = val_o & rdy_i;
  assign all_done_o = &(done_q | fire);
  assign done_d     = start_i ? '0 : done_q | fire;
  always_ff @(posedge clk) done_q <= rst ? '0 : done_d;
endmodule

// File: rtl/tcp_rx_pipe_ctrl.sv
// tcp_rx_pipe_ctrl: steers each RX header onto the fast, new-flow or drop path, one packet at a time
module tcp_rx_pipe_ctrl
  import tcp_rx_pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  tcp_rx_pipe_ctrl_if.master bus,
  output logic [CNT_W-1:0]   pkt_drop_cnt
);
  tcp_rx_ctrl_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       rd_val, rd_all;
  logic [4:0] fast_val, fast_rdy;
  logic [2:0] new_val, new_rdy;
  logic       fast_done, new_done, drop_val;
  assign rd_all = bus.curr_rx_state_rd_req_rdy & bus.curr_tx_state_rd_req_rdy &
                  bus.rx_head_ptr_rd_req_rdy & bus.rx_tail_ptr_rd_req_rdy;
  assign bus.curr_rx_state_rd_req_val = rd_val;
  assign bus.curr_tx_state_rd_req_val = rd_val;
  assign bus.rx_head_ptr_rd_req_val   = rd_val;
  assign bus.rx_tail_ptr_rd_req_val   = rd_val;
  assign fast_rdy = {bus.tcp_rx_dst_hdr_rdy, bus.rx_sched_update_rdy, bus.tx_head_ptr_wr_req_rdy,
                     bus.rx_tail_ptr_wr_req_rdy, bus.next_rx_state_wr_req_rdy};
  assign new_rdy  = {bus.slow_path_send_pkt_enqueue_rdy, bus.app_new_flow_notif_rdy, bus.new_flow_rdy};
  tcp_rx_ctrl_hs_tracker #(.N(5)) u_fast_trk (
    .clk(clk), .rst(rst), .start_i(state_q != FAST_WR), .val_i({5{state_q == FAST_WR}}),
    .rdy_i(fast_rdy), .val_o(fast_val), .all_done_o(fast_done)
  );
  tcp_rx_ctrl_hs_tracker #(.N(3)) u_new_trk (
    .clk(clk), .rst(rst), .start_i(state_q != NEW_WR), .val_i({3{state_q == NEW_WR}}),
    .rdy_i(new_rdy), .val_o(new_val), .all_done_o(new_done)
  );
  assign drop_val                           = state_q == DROP;
  assign bus.next_rx_state_wr_req_val       = fast_val[0];
  assign bus.rx_tail_ptr_wr_req_val         = fast_val[1];
  assign bus.tx_head_ptr_wr_req_val         = fast_val[2];
  assign bus.rx_sched_update_val            = fast_val[3];
  assign bus.tcp_rx_dst_hdr_val             = fast_val[4] | drop_val;
  assign bus.tcp_rx_dst_drop                = drop_val;
  assign bus.new_flow_val                   = new_val[0];
  assign bus.app_new_flow_notif_val         = new_val[1];
  assign bus.slow_path_send_pkt_enqueue_val = new_val[2];
  assign pkt_drop_cnt                       = cnt_q;
  always_comb begin
    state_d                        = state_q;
    cnt_d                          = cnt_q;
    rd_val                         = 1'b0;
    bus.tcp_rx_src_hdr_rdy         = 1'b0;
    bus.ctrl_datap_save_input      = 1'b0;
    bus.read_flow_cam_val          = 1'b0;
    bus.store_flowid_cam           = 1'b0;
    bus.store_flowid_manager       = 1'b0;
    bus.flowid_manager_req         = 1'b0;
    bus.ctrl_datap_save_flow_state = 1'b0;
    bus.ctrl_datap_save_calcs      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.tcp_rx_src_hdr_rdy    = 1'b1;
        bus.ctrl_datap_save_input = bus.src_tcp_rx_hdr_val;
        bus.read_flow_cam_val     = bus.src_tcp_rx_hdr_val;
        if (bus.src_tcp_rx_hdr_val) begin
          if (bus.read_flow_cam_hit && !is_syn(bus.src_tcp_rx_flags)) begin
            bus.store_flowid_cam = 1'b1;
            state_d              = FAST_RD;
          end else if (!bus.read_flow_cam_hit && is_syn(bus.src_tcp_rx_flags) && bus.flowid_manager_avail) begin
            bus.store_flowid_manager = 1'b1;
            bus.flowid_manager_req   = 1'b1;
            state_d                  = NEW_WR;
          end else begin
            state_d = DROP;
          end
        end
      end
      FAST_RD: begin
        rd_val  = 1'b1;
        state_d = rd_all ? FAST_SAVE : FAST_RD;
      end
      FAST_SAVE: begin
        bus.ctrl_datap_save_flow_state = 1'b1;
        state_d                        = FAST_CALC;
      end
      FAST_CALC: begin
        bus.ctrl_datap_save_calcs = 1'b1;
        state_d                   = FAST_WR;
      end
      FAST_WR: state_d = fast_done ? IDLE : FAST_WR;
      NEW_WR:  state_d = new_done ? IDLE : NEW_WR;
      DROP: begin
        state_d = bus.tcp_rx_dst_hdr_rdy ? IDLE : DROP;
        cnt_d   = bus.tcp_rx_dst_hdr_rdy ? cnt_q + 1'b1 : cnt_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    cnt_q   <= rst ? '0 : cnt_d;
  end
endmodule

// File: tb/tb_tcp_rx_pipe_ctrl.sv
// tb_tcp_rx_pipe_ctrl: directed packets with a per-cycle output scoreboard for the RX control FSM
module tb_tcp_rx_pipe_ctrl;
  localparam int CNT_W = 4;
  localparam logic [20:0] QUIET   = 21'h000001;
  localparam logic [20:0] T0_FAST = 21'h00000F;
  localparam logic [20:0] T0_NEW  = 21'h000037;
  localparam logic [20:0] T0_DROP = 21'h000007;
  localparam logic [20:0] RD      = 21'h000F00;
  localparam logic [20:0] SAVE    = 21'h000040;
  localparam logic [20:0] CALC    = 21'h000080;
  localparam logic [20:0] WR      = 21'h01F000;
  localparam logic [20:0] WR3     = 21'h007000;
  localparam logic [20:0] DROPV   = 21'h030000;
  localparam logic [20:0] NEW3    = 21'h1C0000;
  localparam logic [20:0] ENQ     = 21'h100000;
  localparam logic [7:0]  F_ACK   = 8'h10;
  localparam logic [7:0]  F_SYN   = 8'h02;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_en = 1'b0;
  logic [CNT_W-1:0] pkt_drop_cnt;
  logic [20:0] vec;
  logic [20:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  tcp_rx_pipe_ctrl_if bus();
  tcp_rx_pipe_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus), .pkt_drop_cnt(pkt_drop_cnt));
  always #5 clk = ~clk;
  assign vec = {bus.slow_path_send_pkt_enqueue_val, bus.app_new_flow_notif_val, bus.new_flow_val,
                bus.tcp_rx_dst_drop, bus.tcp_rx_dst_hdr_val, bus.rx_sched_update_val,
                bus.tx_head_ptr_wr_req_val, bus.rx_tail_ptr_wr_req_val, bus.next_rx_state_wr_req_val,
                bus.rx_tail_ptr_rd_req_val, bus.rx_head_ptr_rd_req_val, bus.curr_tx_state_rd_req_val,
                bus.curr_rx_state_rd_req_val, bus.ctrl_datap_save_calcs, bus.ctrl_datap_save_flow_state,
                bus.flowid_manager_req, bus.store_flowid_manager, bus.store_flowid_cam,
                bus.read_flow_cam_val, bus.ctrl_datap_save_input, bus.tcp_rx_src_hdr_rdy};
  // every non-idle output cycle must match the next expected vector in order
  always @(negedge clk) begin
    if (mon_en && vec != QUIET) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_activity got=%h want=none", vec);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        if (vec !== e) begin
          n_err++;
          $display("FAIL outputs got=%h want=%h", vec, e);
        end
      end
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic all_rdy(input logic v);
    bus.curr_rx_state_rd_req_rdy       = v;
    bus.curr_tx_state_rd_req_rdy       = v;
    bus.rx_head_ptr_rd_req_rdy         = v;
    bus.rx_tail_ptr_rd_req_rdy         = v;
    bus.next_rx_state_wr_req_rdy       = v;
    bus.rx_tail_ptr_wr_req_rdy         = v;
    bus.tx_head_ptr_wr_req_rdy         = v;
    bus.rx_sched_update_rdy            = v;
    bus.tcp_rx_dst_hdr_rdy             = v;
    bus.new_flow_rdy                   = v;
    bus.app_new_flow_notif_rdy         = v;
    bus.slow_path_send_pkt_enqueue_rdy = v;
  endtask
  task automatic pkt(input logic [7:0] flags, input logic hit, input logic avail);
    bus.src_tcp_rx_hdr_val   = 1'b1;
    bus.src_tcp_rx_flags     = flags;
    bus.read_flow_cam_hit    = hit;
    bus.flowid_manager_avail = avail;
    tick(1);
    bus.src_tcp_rx_hdr_val   = 1'b0;
    bus.read_flow_cam_hit    = 1'b0;
    bus.flowid_manager_avail = 1'b0;
  endtask
  task automatic push_fast();
    exp_q.push_back(T0_FAST);
    exp_q.push_back(RD);
    exp_q.push_back(SAVE);
    exp_q.push_back(CALC);
    exp_q.push_back(WR);
  endtask
  task automatic drop_pkt(input logic [7:0] flags, input logic hit, input logic avail);
    exp_q.push_back(T0_DROP);
    exp_q.push_back(DROPV);
    pkt(flags, hit, avail);
    tick(1);
  endtask
  initial begin
    bus.src_tcp_rx_hdr_val   = 1'b0;
    bus.src_tcp_rx_flags     = 8'h00;
    bus.read_flow_cam_hit    = 1'b0;
    bus.flowid_manager_avail = 1'b0;
    all_rdy(1'b1);
    tick(2);
    rst = 1'b0;
    mon_en = 1'b1;
    chk("reset_outputs", int'(vec), int'(QUIET));
    chk("reset_cnt", int'(pkt_drop_cnt), 0);
    push_fast();
    pkt(F_ACK, 1'b1, 1'b0);
    tick(4);
    chk("fast_idle_t5", int'(vec), int'(QUIET));
    exp_q.push_back(T0_NEW);
    exp_q.push_back(NEW3);
    repeat (3) exp_q.push_back(ENQ);
    bus.slow_path_send_pkt_enqueue_rdy = 1'b0;
    pkt(F_SYN, 1'b0, 1'b1);
    tick(3);
    bus.slow_path_send_pkt_enqueue_rdy = 1'b1;
    tick(1);
    chk("new_idle_t5", int'(vec), int'(QUIET));
    drop_pkt(F_ACK, 1'b0, 1'b0);
    chk("drop_miss_cnt", int'(pkt_drop_cnt), 1);
    drop_pkt(F_SYN, 1'b0, 1'b0);
    chk("drop_noavail_cnt", int'(pkt_drop_cnt), 2);
    drop_pkt(F_SYN, 1'b1, 1'b1);
    chk("drop_dupsyn_cnt", int'(pkt_drop_cnt), 3);
    exp_q.push_back(T0_FAST);
    repeat (5) exp_q.push_back(RD);
    exp_q.push_back(SAVE);
    exp_q.push_back(CALC);
    exp_q.push_back(WR);
    bus.rx_tail_ptr_rd_req_rdy = 1'b0;
    pkt(F_ACK, 1'b1, 1'b0);
    tick(4);
    bus.rx_tail_ptr_rd_req_rdy = 1'b1;
    tick(4);
    chk("rd_bp_idle", int'(vec), int'(QUIET));
    push_fast();
    exp_q.push_back(WR3);
    bus.next_rx_state_wr_req_rdy = 1'b0;
    bus.rx_tail_ptr_wr_req_rdy   = 1'b0;
    bus.tx_head_ptr_wr_req_rdy   = 1'b0;
    pkt(F_ACK, 1'b1, 1'b0);
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_outputs", int'(vec), int'(QUIET));
    chk("midrst_cnt", int'(pkt_drop_cnt), 0);
    all_rdy(1'b1);
    push_fast();
    pkt(F_ACK, 1'b1, 1'b0);
    tick(4);
    chk("post_rst_idle", int'(vec), int'(QUIET));
    for (int i = 0; i < 15; i++) drop_pkt(F_ACK, 1'b0, 1'b0);
    chk("cnt_max", int'(pkt_drop_cnt), 15);
    drop_pkt(F_ACK, 1'b0, 1'b0);
    chk("cnt_wrap", int'(pkt_drop_cnt), 0);
    tick(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
